stroke_phase_detector: RTL

- Generates the start_drive / start_recovery event pulses consumed by the stroke-ratio counter/divider.
- Input is the raw flywheel hall-sensor signal. The block synchronises and debounces it, measures cycles between flywheel ticks, and classifies the stroke phase:
  - drive = flywheel accelerating, so intervals shrink;
  - recovery = flywheel decelerating, so intervals grow.
- Also reports stroke count and last tick interval for the display path.

---
 rtl/stroke_pkg.sv | 12 +
 rtl/stroke_phase_detector_if.sv | 21 ++
 rtl/stroke_phase_detector_sensor_conditioner.sv | 43 ++++
 rtl/stroke_phase_detector.sv | 116 +++++++++++
 4 files changed

// File: rtl/stroke_pkg.sv
// Shared definitions for the stroke phase detector: phase encoding and default widths.
package stroke_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_DRIVE    = 2'd1,
    PH_RECOVERY = 2'd2
  } phase_e;

endpackage

// File: rtl/stroke_phase_detector_if.sv
// Sensor input and stroke-event outputs of the stroke phase detector.
interface stroke_phase_detector_if #(
  parameter int CNT_W = 32
);
  logic             sensor_in;
  logic             start_drive;
  logic             start_recovery;
  logic [1:0]       phase;
  logic [CNT_W-1:0] stroke_count;
  logic [CNT_W-1:0] last_interval;

  modport master (
    output sensor_in,
    input  start_drive, start_recovery, phase, stroke_count, last_interval
  );

  modport slave (
    input  sensor_in,
    output start_drive, start_recovery, phase, stroke_count, last_interval
  );
endinterface

// File: rtl/stroke_phase_detector_sensor_conditioner.sv
// Two-flop synchroniser plus debounce for a raw hall sensor; emits a one-cycle
// tick on each accepted rising edge. Shared with the handle-position sensor.
module sensor_conditioner #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_i,
  output logic tick_o
);
  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic [1:0]      sync_q;
  logic            level_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            tick_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sensor_i};
      tick_q <= 1'b0;
      // The level flips only once the synchronised value has disagreed for DEBOUNCE cycles.
      if (sync_q[1] != level_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
          level_q  <= sync_q[1];
          db_cnt_q <= '0;
          tick_q   <= sync_q[1];
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign tick_o = tick_q;
endmodule

// File: rtl/stroke_phase_detector.sv
// Classifies flywheel ticks into drive/recovery phases from the trend of
// tick-to-tick intervals, and pulses start_drive / start_recovery on entry.
module stroke_phase_detector
  import stroke_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DEBOUNCE  = 4,
  parameter int HYST      = 2,
  parameter int MIN_DELTA = 0,
  parameter int TIMEOUT   = 50000000
) (
  input logic clk,
  input logic reset,
  stroke_phase_detector_if.slave bus
);
  localparam int SW = (HYST < 1) ? 1 : $clog2(HYST + 1);
  localparam logic [SW-1:0] HYST_L = SW'(HYST);

  logic             tick;
  logic [CNT_W-1:0] cnt_q, prev_q, last_q, stroke_q;
  logic             prev_valid_q;
  logic [SW-1:0]    accel_q, decel_q, accel_d, decel_d;
  phase_e           phase_q;
  logic             start_drive_q, start_recovery_q;
  logic             accel, decel, timeout;
  logic [CNT_W:0]   cur_x, prev_x, delta_x;

  sensor_conditioner #(.DEBOUNCE(DEBOUNCE)) u_cond (
    .clk      (clk),
    .reset    (reset),
    .sensor_i (bus.sensor_in),
    .tick_o   (tick)
  );

  // One extra bit keeps the MIN_DELTA margin from wrapping near saturation.
  always_comb begin
    cur_x   = {1'b0, cnt_q};
    prev_x  = {1'b0, prev_q};
    delta_x = (CNT_W + 1)'(MIN_DELTA);
    accel   = prev_valid_q && ((cur_x + delta_x) < prev_x);
    decel   = prev_valid_q && (cur_x > (prev_x + delta_x));
    accel_d = accel_q;
    decel_d = decel_q;
    if (accel) begin
      accel_d = (accel_q == HYST_L) ? accel_q : accel_q + SW'(1);
      decel_d = '0;
    end else if (decel) begin
      decel_d = (decel_q == HYST_L) ? decel_q : decel_q + SW'(1);
      accel_d = '0;
    end
    timeout = !tick && (cnt_q == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q            <= '0;
      prev_q           <= '0;
      last_q           <= '0;
      stroke_q         <= '0;
      prev_valid_q     <= 1'b0;
      accel_q          <= '0;
      decel_q          <= '0;
      phase_q          <= PH_IDLE;
      start_drive_q    <= 1'b0;
      start_recovery_q <= 1'b0;
    end else begin
      start_drive_q    <= 1'b0;
      start_recovery_q <= 1'b0;
      cnt_q <= tick ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
      if (tick) begin
        last_q       <= cnt_q;
        prev_q       <= cnt_q;
        prev_valid_q <= 1'b1;
        accel_q      <= accel_d;
        decel_q      <= decel_d;
        case (phase_q)
          PH_IDLE: begin
            if (accel && accel_d == HYST_L) begin
              phase_q       <= PH_DRIVE;
              start_drive_q <= 1'b1;
            end
          end
          PH_DRIVE: begin
            if (decel && decel_d == HYST_L) begin
              phase_q          <= PH_RECOVERY;
              start_recovery_q <= 1'b1;
              accel_q          <= '0;
              decel_q          <= '0;
            end
          end
          PH_RECOVERY: begin
            if (accel && accel_d == HYST_L) begin
              phase_q       <= PH_DRIVE;
              start_drive_q <= 1'b1;
              stroke_q      <= stroke_q + CNT_W'(1);
              accel_q       <= '0;
              decel_q       <= '0;
            end
          end
          default: phase_q <= PH_IDLE;
        endcase
      end else if (timeout) begin
        phase_q      <= PH_IDLE;
        prev_valid_q <= 1'b0;
        accel_q      <= '0;
        decel_q      <= '0;
      end
    end
  end

  assign bus.start_drive    = start_drive_q;
  assign bus.start_recovery = start_recovery_q;
  assign bus.phase          = phase_q;
  assign bus.stroke_count   = stroke_q;
  assign bus.last_interval  = last_q;
endmodule
